// File: rtl/mem_stage_dm.sv
// mem_stage_dm: MEM stage of the five-stage MIPS pipeline.
//   Holds the DM_WORDS x 32 data memory. Stores (word/half/byte) commit on the
//   rising clk edge; loads are combinational, sign- or zero-extended.
//   Selects the write-back value (ALU result, load data, PC+8) and passes the
//   hazard-tracking fields through to MEM/WB unchanged.
// Ports:
//   clk, reset       pipeline clock; async active-low reset clears memory
//   InstrIn/curPCIn  instruction and PC in MEM (pass-through, PC feeds PC+8)
//   ALUResIn         ALU result / effective byte address
//   StoreDataIn      forwarded rt value for stores
//   MemWrite, MemOp  store strobe and access type (0 none,1 w,2 h,3 hu,4 b,5 bu)
//   WBSel            0 ALU, 1 load data, 2 PC+8, 3 ALU
//   WriteAddrIn/RegWriteIn/TnewIn  destination info, passed through
//   GRFWDataOut      write-back value; MemRData extended load data
module mem_stage_dm #(
  parameter int DM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrIn,
  input  logic [31:0] curPCIn,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] StoreDataIn,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  input  logic [1:0]  WBSel,
  input  logic [4:0]  WriteAddrIn,
  input  logic        RegWriteIn,
  input  logic [1:0]  TnewIn,
  output logic [31:0] GRFWDataOut,
  output logic [31:0] InstrOut,
  output logic [31:0] curPCOut,
  output logic [4:0]  WriteAddrOut,
  output logic        RegWriteOut,
  output logic [1:0]  TnewOut,
  output logic [31:0] MemRData
);
  localparam int AW = $clog2(DM_WORDS);

  logic [31:0]   mem [DM_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   cur_w, wrep, new_w;
  logic [3:0]    be;
  logic [15:0]   hsel;
  logic [7:0]    bsel;

  // Upper address bits are dropped: the memory wraps.
  assign idx   = ALUResIn[AW+1:2];
  assign cur_w = mem[idx];

  // Byte enables and lane-replicated store data.
  always_comb begin
    be   = '0;
    wrep = StoreDataIn;
    case (MemOp)
      3'd1: be = 4'hF;
      3'd2, 3'd3: begin
        be   = ALUResIn[1] ? 4'hC : 4'h3;
        wrep = {2{StoreDataIn[15:0]}};
      end
      3'd4, 3'd5: begin
        be   = 4'b0001 << ALUResIn[1:0];
        wrep = {4{StoreDataIn[7:0]}};
      end
      default: be = '0;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign new_w[8*g +: 8] = be[g] ? wrep[8*g +: 8] : cur_w[8*g +: 8];
  end

  // An X MemWrite takes the else path of the if, so memory stays intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (MemWrite && (be != 4'h0)) begin
      mem[idx] <= new_w;
      $display("@%h: *%h <= %h", curPCIn, {ALUResIn[31:2], 2'b00}, new_w);
    end
  end

  assign hsel = ALUResIn[1] ? cur_w[31:16] : cur_w[15:0];
  assign bsel = cur_w[8*ALUResIn[1:0] +: 8];

  always_comb begin
    MemRData = '0;
    case (MemOp)
      3'd1:    MemRData = cur_w;
      3'd2:    MemRData = {{16{hsel[15]}}, hsel};
      3'd3:    MemRData = {16'h0, hsel};
      3'd4:    MemRData = {{24{bsel[7]}}, bsel};
      3'd5:    MemRData = {24'h0, bsel};
      default: MemRData = '0;
    endcase
  end

  always_comb begin
    case (WBSel)
      2'd1:    GRFWDataOut = MemRData;
      2'd2:    GRFWDataOut = curPCIn + 32'd8;
      default: GRFWDataOut = ALUResIn;
    endcase
  end

  assign InstrOut     = InstrIn;
  assign curPCOut     = curPCIn;
  assign WriteAddrOut = WriteAddrIn;
  assign RegWriteOut  = RegWriteIn;
  assign TnewOut      = TnewIn;
endmodule

// File: tb/tb_mem_stage_dm.sv
module tb_mem_stage_dm;
  logic        clk = 0, reset = 1;
  logic [31:0] InstrIn = 0, curPCIn = 0, ALUResIn = 0, StoreDataIn = 0;
  logic        MemWrite = 0;
  logic [2:0]  MemOp = 0;
  logic [1:0]  WBSel = 0;
  logic [4:0]  WriteAddrIn = 0;
  logic        RegWriteIn = 0;
  logic [1:0]  TnewIn = 0;
  logic [31:0] GRFWDataOut, InstrOut, curPCOut, MemRData;
  logic [4:0]  WriteAddrOut;
  logic        RegWriteOut;
  logic [1:0]  TnewOut;

  int n_cmp = 0, n_fail = 0;
  logic [31:0] ref_mem [4096];

  mem_stage_dm dut (
    .clk(clk), .reset(reset), .InstrIn(InstrIn), .curPCIn(curPCIn),
    .ALUResIn(ALUResIn), .StoreDataIn(StoreDataIn), .MemWrite(MemWrite),
    .MemOp(MemOp), .WBSel(WBSel), .WriteAddrIn(WriteAddrIn),
    .RegWriteIn(RegWriteIn), .TnewIn(TnewIn), .GRFWDataOut(GRFWDataOut),
    .InstrOut(InstrOut), .curPCOut(curPCOut), .WriteAddrOut(WriteAddrOut),
    .RegWriteOut(RegWriteOut), .TnewOut(TnewOut), .MemRData(MemRData)
  );

  always #5 clk = ~clk;

  // Reference model: memory as word array, lanes via shift/mask arithmetic.
  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] op);
    int w; int sh; logic [31:0] m;
    w = int'(a[13:2]);
    if (op == 1) ref_mem[w] = d;
    else if (op == 2 || op == 3) begin
      sh = int'(a[1]) * 16; m = 32'hFFFF << sh;
      ref_mem[w] = (ref_mem[w] & ~m) | ((d & 32'hFFFF) << sh);
    end else if (op == 4 || op == 5) begin
      sh = int'(a[1:0]) * 8; m = 32'hFF << sh;
      ref_mem[w] = (ref_mem[w] & ~m) | ((d & 32'hFF) << sh);
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] w; longint v;
    w = ref_mem[int'(a[13:2])];
    case (op)
      1: return w;
      2, 3: begin
        v = longint'((w >> (int'(a[1]) * 16)) & 32'hFFFF);
        if (op == 2 && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      4, 5: begin
        v = longint'((w >> (int'(a[1:0]) * 8)) & 32'hFF);
        if (op == 4 && v >= 128) v = v - 256;
        return 32'(v);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wb(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] ld, input logic [31:0] pc);
    if (sel == 1) return ld;
    if (sel == 2) return 32'(longint'(pc) + 8);
    return alu;
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    @(negedge clk);
    ALUResIn = a; StoreDataIn = d; MemOp = op; MemWrite = 1; WBSel = 0;
    @(posedge clk);
    model_store(a, d, op);
    #1 MemWrite = 0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] op, input logic [1:0] sel);
    @(negedge clk);
    MemWrite = 0; ALUResIn = a; MemOp = op; WBSel = sel;
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 0;
    #2 reset = 1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 0;
    set_load(32'h40, 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp %h", MemRData, 32'h0); end
    n_cmp++; if (GRFWDataOut !== 32'h0) begin n_fail++; $display("FAIL reset_wb got %h exp %h", GRFWDataOut, 32'h0); end
    set_load(32'h0, 3'd0, 2'd0);
    n_cmp++; if ({GRFWDataOut, InstrOut, curPCOut, WriteAddrOut, RegWriteOut, TnewOut, MemRData} !== '0) begin
      n_fail++; $display("FAIL reset_all_zero got wb=%h rd=%h exp 0", GRFWDataOut, MemRData); end
  endtask

  task automatic test_directed;
    logic [31:0] ops [8] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h102, 32'h102, 32'h0, 32'h0};
    curPCIn = 32'h0000_3010;
    do_store(32'h100, 32'h8899AABB, 3'd1);
    set_load(32'h100, 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_100 got %h exp %h", MemRData, 32'h8899AABB); end
    do_store(32'h101, 32'h0000007F, 3'd4);
    set_load(32'h100, 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'h88997FBB) begin n_fail++; $display("FAIL sb_merge got %h exp %h", MemRData, 32'h88997FBB); end
    set_load(ops[0], 3'd4, 2'd1);
    n_cmp++; if (MemRData !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_103 got %h exp %h", MemRData, 32'hFFFFFF88); end
    set_load(ops[1], 3'd5, 2'd1);
    n_cmp++; if (GRFWDataOut !== 32'h00000088) begin n_fail++; $display("FAIL lbu_103 got %h exp %h", GRFWDataOut, 32'h00000088); end
    do_store(32'h102, 32'hABCD1234, 3'd2);
    set_load(ops[3], 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'h12347FBB) begin n_fail++; $display("FAIL sh_merge got %h exp %h", MemRData, 32'h12347FBB); end
    set_load(ops[2], 3'd2, 2'd1);
    n_cmp++; if (MemRData !== 32'h00001234) begin n_fail++; $display("FAIL lh_pos got %h exp %h", MemRData, 32'h00001234); end
    do_store(32'h102, 32'h0000F00D, 3'd3);
    set_load(ops[4], 3'd2, 2'd1);
    n_cmp++; if (MemRData !== 32'hFFFFF00D) begin n_fail++; $display("FAIL lh_neg got %h exp %h", MemRData, 32'hFFFFF00D); end
    set_load(ops[5], 3'd3, 2'd1);
    n_cmp++; if (MemRData !== 32'h0000F00D) begin n_fail++; $display("FAIL lhu got %h exp %h", MemRData, 32'h0000F00D); end
  endtask

  task automatic test_wrap_wbsel;
    do_store(32'h0000_4100, 32'hCAFEBABE, 3'd1);
    set_load(32'h100, 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'hCAFEBABE) begin n_fail++; $display("FAIL wrap_alias got %h exp %h", MemRData, 32'hCAFEBABE); end
    curPCIn = 32'h3000;
    set_load(32'h100, 3'd1, 2'd2);
    n_cmp++; if (GRFWDataOut !== 32'h3008) begin n_fail++; $display("FAIL wb_pc8 got %h exp %h", GRFWDataOut, 32'h3008); end
    curPCIn = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (GRFWDataOut !== 32'h4) begin n_fail++; $display("FAIL wb_pc8_wrap got %h exp %h", GRFWDataOut, 32'h4); end
    set_load(32'h100, 3'd1, 2'd3);
    n_cmp++; if (GRFWDataOut !== 32'h100) begin n_fail++; $display("FAIL wb_sel3 got %h exp %h", GRFWDataOut, 32'h100); end
    // MemWrite with MemOp 0/6/7 must not write.
    do_store(32'h100, 32'h11111111, 3'd6);
    do_store(32'h100, 32'h22222222, 3'd0);
    set_load(32'h100, 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'hCAFEBABE) begin n_fail++; $display("FAIL nowrite_op got %h exp %h", MemRData, 32'hCAFEBABE); end
  endtask

  task automatic test_random;
    logic [31:0] a, d, exp_rd;
    logic [2:0] op; logic [1:0] sel;
    for (int i = 0; i < 300; i++) begin
      a = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'h0, 8'h0, 6'($urandom)};
      if ($urandom_range(0, 1) == 1) do_store(a, $urandom, 3'($urandom));
      a = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'h0, 8'h0, 6'($urandom)};
      op = 3'($urandom); sel = 2'($urandom);
      curPCIn = $urandom; InstrIn = $urandom; WriteAddrIn = 5'($urandom);
      RegWriteIn = 1'($urandom); TnewIn = 2'($urandom);
      set_load(a, op, sel);
      exp_rd = model_load(a, op);
      n_cmp++; if (MemRData !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata a=%h op=%0d got %h exp %h", a, op, MemRData, exp_rd); end
      n_cmp++; if (GRFWDataOut !== model_wb(sel, a, exp_rd, curPCIn)) begin n_fail++;
        $display("FAIL rnd_wb sel=%0d got %h exp %h", sel, GRFWDataOut, model_wb(sel, a, exp_rd, curPCIn)); end
      n_cmp++; if ({InstrOut, curPCOut, WriteAddrOut, RegWriteOut, TnewOut} !==
                   {InstrIn, curPCIn, WriteAddrIn, RegWriteIn, TnewIn}) begin n_fail++;
        $display("FAIL rnd_pass got %h/%h/%h/%b/%h", InstrOut, curPCOut, WriteAddrOut, RegWriteOut, TnewOut); end
    end
  endtask

  task automatic test_async_reset;
    logic bad;
    TnewIn = 2'd2;
    do_store(32'h200, 32'h5A5A5A5A, 3'd1);
    @(negedge clk);
    ALUResIn = 32'h200; StoreDataIn = 32'hDEADBEEF; MemOp = 3'd1; MemWrite = 1;
    #2 reset = 0;
    #1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 0;
    n_cmp++; if (MemRData !== 32'h0) begin n_fail++; $display("FAIL async_clear got %h exp %h", MemRData, 32'h0); end
    @(posedge clk); #1;
    n_cmp++; if (MemRData !== 32'h0) begin n_fail++; $display("FAIL no_commit_in_reset got %h exp %h", MemRData, 32'h0); end
    n_cmp++; if (TnewOut !== 2'd2) begin n_fail++; $display("FAIL tnew_pass got %0d exp 2", TnewOut); end
    @(negedge clk); MemWrite = 0; reset = 1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      ALUResIn = 32'($urandom_range(0, 4095) * 4); #1;
      if (MemRData !== 32'h0) bad = 1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL mem_all_zero got nonzero exp 0"); end
    // First edge after release commits normally.
    do_store(32'h300, 32'h0BADF00D, 3'd1);
    set_load(32'h300, 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'h0BADF00D) begin n_fail++; $display("FAIL post_reset_store got %h exp %h", MemRData, 32'h0BADF00D); end
    n_cmp++; if (TnewOut !== 2'd2) begin n_fail++; $display("FAIL tnew_after got %0d exp 2", TnewOut); end
    // Non-1 MemWrite must leave memory untouched.
    @(negedge clk);
    ALUResIn = 32'h300; StoreDataIn = 32'h0; MemOp = 3'd1; MemWrite = 1'bx;
    @(posedge clk); #1 MemWrite = 0;
    set_load(32'h300, 3'd1, 2'd1);
    n_cmp++; if (MemRData !== 32'h0BADF00D) begin n_fail++; $display("FAIL x_memwrite got %h exp %h", MemRData, 32'h0BADF00D); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_wrap_wbsel;
    test_random;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_dm.md
# mem_stage_dm

Memory-access stage of the five-stage MIPS pipeline: it holds the 4096-word data memory and sits between the EX/MEM pipeline register and the MEM/WB register. It performs word/half/byte stores on the clock edge and sign- or zero-extends loads combinationally. It selects the register write-back value (ALU result, load data, or PC+8) and forwards the hazard-tracking fields unchanged to MEM/WB.

## Interface
- DM_WORDS, 4096, number of 32-bit words in data memory (index = Addr[13:2])
- clk  input  1  pipeline clock; stores commit on rising edge
- reset  input  1  asynchronous, active-low; clears memory array
- InstrIn  input  32  instruction in MEM; passed to InstrOut
- curPCIn  input  32  PC of instruction in MEM; passed to curPCOut
- ALUResIn  input  32  ALU result / effective byte address
- StoreDataIn  input  32  forwarded rt value for stores
- MemWrite  input  1  1 = store this cycle
- MemOp  input  3  0 none, 1 word, 2 half signed, 3 half unsigned, 4 byte signed, 5 byte unsigned; 6–7 treated as 0
- WBSel  input  2  0 ALU result, 1 load data, 2 curPCIn+8, 3 treated as 0
- WriteAddrIn / RegWriteIn / TnewIn  input  5/1/2  destination info from EX/MEM
- GRFWDataOut  output  32  write-back value for MEM/WB GRFWDataIn
- InstrOut, curPCOut, WriteAddrOut, RegWriteOut, TnewOut  output  32/32/5/1/2  pass-through
- MemRData  output  32  extended load data (for forwarding/debug)

## Operation
- Word index = ALUResIn[13:2]; higher address bits ignored (wrap modulo 16 KiB).
- Store (MemWrite=1, rising clk, reset high): MemOp 1 writes all 32 bits; MemOp 2/3 writes StoreDataIn[15:0] into half ALUResIn[1] (0 = bits 15:0, 1 = bits 31:16), ALUResIn[0] ignored; MemOp 4/5 writes StoreDataIn[7:0] into byte lane ALUResIn[1:0]; other bytes unchanged. MemWrite=1 with MemOp 0/6/7: no write.
- Each committed store prints "@%h: *%h <= %h" (curPCIn, word-aligned address, full new word) via $display.
- Load: MemRData = selected lane of current word, sign-extended (2, 4) or zero-extended (3, 5); MemOp 1 full word; MemOp 0 gives 0. Purely combinational from current array contents.
- GRFWDataOut per WBSel; PC+8 addition wraps mod 2^32.
- Pass-through outputs are combinational copies of inputs; Tnew is NOT decremented here (MEM/WB does that).

## Timing
- Reset assertion (falling reset) immediately clears every memory word to 0, regardless of clk; no store commits at an edge while reset is low.
- Reset deasserted mid-stream: first edge with reset high commits normally.
- Load latency 0 cycles (same-cycle combinational); store visible to a load from the following cycle onward.
- Store then load of same word in consecutive cycles: load returns merged new word.
- Outputs have no reset value of their own: all are functions of inputs and array; after reset with all inputs 0, every output is 0 except none (GRFWDataOut = 0 with WBSel=0).
- X on MemWrite must not corrupt memory (treat non-1 as no write).

## Test plan
- Reset low, then high; MemOp=1 load at 0x0000_0040 -> MemRData=0, GRFWDataOut (WBSel=1)=0.
- sw 0x8899AABB at 0x100, next cycle lw 0x100 -> 0x8899AABB; display "@<pc>: *00000100 <= 8899aabb".
- sb 0x7F at 0x101 over that word -> word 0x88997FBB; lb 0x103 -> 0xFFFFFF88; lbu 0x103 -> 0x00000088.
- sh 0x1234 at 0x102 -> word 0x12347FBB; lh 0x102 -> 0x00001234; sh 0xF00D then lh -> 0xFFFFF00D, lhu -> 0x0000F00D.
- Store to 0x0000_4100 -> aliases word 0x100 (wrap); WBSel=2 with curPCIn=0x3000 -> 0x3008; WBSel=3 -> ALUResIn.
- Assert reset low between edges while MemWrite=1 -> memory all zero, no store/display at next edge; TnewIn=2 -> TnewOut=2 throughout.
